// File: rtl/core_fetch_buf_if.sv
// Bundle of the fetch-buffer handshakes: IF address/stall, L1I request and
// response, and the decode-side {pc, instr} queue head.
interface core_fetch_buf_if;
  logic        fetch_val_in;
  logic [31:0] fetch_addr_in;
  logic        fetch_rdy_out;
  logic        stall_out;
  logic        kill_in;
  logic        l1i_req_val_out;
  logic [31:0] l1i_req_addr_out;
  logic        l1i_req_ack_in;
  logic        l1i_resp_val_in;
  logic [31:0] l1i_resp_data_in;
  logic        dec_val_out;
  logic [31:0] dec_pc_out;
  logic [31:0] dec_instr_out;
  logic        dec_rdy_in;

  // The fetch buffer itself
  modport master (
    input  fetch_val_in, fetch_addr_in, kill_in,
    input  l1i_req_ack_in, l1i_resp_val_in, l1i_resp_data_in, dec_rdy_in,
    output fetch_rdy_out, stall_out, l1i_req_val_out, l1i_req_addr_out,
    output dec_val_out, dec_pc_out, dec_instr_out
  );

  // IF stage, L1I cache and decode stage as seen from the buffer
  modport slave (
    output fetch_val_in, fetch_addr_in, kill_in,
    output l1i_req_ack_in, l1i_resp_val_in, l1i_resp_data_in, dec_rdy_in,
    input  fetch_rdy_out, stall_out, l1i_req_val_out, l1i_req_addr_out,
    input  dec_val_out, dec_pc_out, dec_instr_out
  );
endinterface

// File: rtl/core_fetch_buf.sv
// Fetch-request controller and instruction buffer between IF, L1I and decode.
// Issues one PC at a time to L1I, queues {pc, instr} pairs for decode and
// throws away in-flight or queued fetches on a redirect (kill).
module core_fetch_buf #(
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input logic            clk,
  input logic            n_rst,
  core_fetch_buf_if.master bus
);

  localparam int             PW       = $clog2(DEPTH);
  localparam logic [PW:0]    DEPTH_C  = (PW + 1)'(DEPTH);
  localparam logic [PW-1:0]  PTR_ONE  = PW'(32'd1);
  localparam logic [PW:0]    CNT_ONE  = (PW + 1)'(32'd1);
  localparam logic [PW:0]    CNT_ZERO = (PW + 1)'(32'd0);
  localparam logic [PW-1:0]  PTR_ZERO = PW'(32'd0);

  // IDLE: free to accept; REQ: request shown to L1I; WAIT: acked, awaiting
  // response; DROP: acked but killed, swallow the response when it arrives.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic          req_val_r;
  logic [31:0]   req_addr_r;
  logic [31:0]   pc_mem_r    [DEPTH];
  logic [31:0]   instr_mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [PW:0]   count_r;

  logic          not_empty_s;
  logic          fetch_rdy_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;

  // Handshake qualifiers; kill blocks new issue, pushes and pops alike
  always_comb begin
    not_empty_s = 1'b0;
    fetch_rdy_s = 1'b0;
    accept_s    = 1'b0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    not_empty_s = (count_r != CNT_ZERO);
    fetch_rdy_s = (state_r == IDLE) && (count_r < DEPTH_C) && !bus.kill_in;
    accept_s    = bus.fetch_val_in && fetch_rdy_s;
    push_s      = (state_r == WAIT) && bus.l1i_resp_val_in && !bus.kill_in;
    pop_s       = not_empty_s && bus.dec_rdy_in && !bus.kill_in;
  end

  // Next-state logic of the single-outstanding-request controller
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = REQ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (bus.l1i_req_ack_in) begin
          if (bus.kill_in) begin
            state_nxt_s = DROP;
          end else begin
            state_nxt_s = WAIT;
          end
        end else if (bus.kill_in) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REQ;
        end
      end
      WAIT: begin
        if (bus.l1i_resp_val_in) begin
          state_nxt_s = IDLE;
        end else if (bus.kill_in) begin
          state_nxt_s = DROP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      DROP: begin
        if (bus.l1i_resp_val_in) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DROP;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Controller state register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // L1I request valid and word-aligned address, both registered
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      req_val_r  <= 1'b0;
      req_addr_r <= 32'h0000_0000;
    end else begin
      req_val_r <= (state_nxt_s == REQ);
      if (accept_s) begin
        req_addr_r <= {bus.fetch_addr_in[31:2], 2'b00};
      end
    end
  end

  // Queue pointers and occupancy; kill empties the queue outright
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else if (bus.kill_in) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Queue storage for {pc, instr} pairs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]    <= 32'h0000_0000;
        instr_mem_r[i] <= NOP;
      end
    end else if (push_s) begin
      pc_mem_r[wr_ptr_r]    <= req_addr_r;
      instr_mem_r[wr_ptr_r] <= bus.l1i_resp_data_in;
    end
  end

  assign bus.fetch_rdy_out    = fetch_rdy_s;
  assign bus.stall_out        = bus.fetch_val_in & ~fetch_rdy_s;
  assign bus.l1i_req_val_out  = req_val_r;
  assign bus.l1i_req_addr_out = req_addr_r;
  assign bus.dec_val_out      = not_empty_s;
  assign bus.dec_pc_out       = not_empty_s ? pc_mem_r[rd_ptr_r] : 32'h0000_0000;
  assign bus.dec_instr_out    = not_empty_s ? instr_mem_r[rd_ptr_r] : NOP;

endmodule
